// File: rtl/lock_key_loader.sv
// Serial unlock-key loader for a logic-locked netlist: shifts key bits in LSB first and commits them atomically.
// Optional trailing even-parity bit check is enabled by defining LOCK_KEY_PARITY_EN.
module lock_key_loader #(
  parameter int KEY_WIDTH = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 key_in_bit,
  input  logic                 key_in_valid,
  output logic                 key_in_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 load_error
);

  localparam int CNT_W = $clog2(KEY_WIDTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

`ifdef LOCK_KEY_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    COMMIT = 3'd3,
    ERROR  = 3'd4
  } state_t;

  function automatic logic parity_even(input logic [KEY_WIDTH-1:0] data, input logic p);
    return ~(^data ^ p);
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    COMMIT = 3'd3,
    ERROR  = 3'd4
  } state_t;
`endif

  state_t               state_r;
  state_t               state_nxt_s;
  logic [KEY_WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [TMO_W-1:0]     tmo_r;
  logic                 xfer_s;
  logic                 tmo_hit_s;

  // Next-state decode; load_start overrides everything, including a same-cycle transfer.
  always_comb begin
    xfer_s      = key_in_valid && key_in_ready;
    tmo_hit_s   = !xfer_s && (tmo_r == TMO_LAST);
    state_nxt_s = state_r;
    if (load_start) begin
      state_nxt_s = SHIFT;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        SHIFT: begin
          if (tmo_hit_s) begin
            state_nxt_s = ERROR;
          end else if (xfer_s && (cnt_r == LAST_BIT)) begin
`ifdef LOCK_KEY_PARITY_EN
            state_nxt_s = PARITY;
`else
            state_nxt_s = COMMIT;
`endif
          end else begin
            state_nxt_s = SHIFT;
          end
        end
`ifdef LOCK_KEY_PARITY_EN
        PARITY: begin
          if (tmo_hit_s) begin
            state_nxt_s = ERROR;
          end else if (xfer_s) begin
            state_nxt_s = parity_even(shreg_r, key_in_bit) ? COMMIT : ERROR;
          end else begin
            state_nxt_s = PARITY;
          end
        end
`endif
        COMMIT: begin
          state_nxt_s = IDLE;
        end
        ERROR: begin
          state_nxt_s = ERROR;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State register, datapath and registered outputs; key_out only moves on clear, commit or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      shreg_r      <= '0;
      cnt_r        <= '0;
      tmo_r        <= '0;
      key_out      <= '0;
      key_valid    <= 1'b0;
      busy         <= 1'b0;
      key_in_ready <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
`ifdef LOCK_KEY_PARITY_EN
      key_in_ready <= (state_nxt_s == SHIFT) || (state_nxt_s == PARITY);
      busy         <= (state_nxt_s == SHIFT) || (state_nxt_s == PARITY) || (state_nxt_s == COMMIT);
`else
      key_in_ready <= (state_nxt_s == SHIFT);
      busy         <= (state_nxt_s == SHIFT) || (state_nxt_s == COMMIT);
`endif
      if (load_start) begin
        shreg_r    <= '0;
        cnt_r      <= '0;
        tmo_r      <= '0;
        key_out    <= '0;
        key_valid  <= 1'b0;
        load_error <= 1'b0;
      end else begin
        // key_in_ready is high exactly while a load is waiting for bits.
        if (key_in_ready) begin
          if (xfer_s) begin
            tmo_r <= '0;
          end else if (tmo_r != TMO_LAST) begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        if (xfer_s && (state_r == SHIFT)) begin
          shreg_r <= {key_in_bit, shreg_r[KEY_WIDTH-1:1]};
          cnt_r   <= cnt_r + CNT_W'(1);
        end
        if (state_r == COMMIT) begin
          key_out   <= shreg_r;
          key_valid <= 1'b1;
        end
        if (state_nxt_s == ERROR) begin
          load_error <= 1'b1;
          key_out    <= '0;
          key_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// Randomized self-checking bench for lock_key_loader against a bit-queue reference model.
module tb_lock_key_loader;

  localparam int W   = 32;
  localparam int TMO = 16;
`ifdef LOCK_KEY_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif
  localparam int LAT = NBITS + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          key_in_bit;
  logic          key_in_valid;
  logic          key_in_ready;
  logic [W-1:0]  key_out;
  logic          key_valid;
  logic          busy;
  logic          load_error;

  int n_cmp = 0;
  int n_bad = 0;

  lock_key_loader #(.KEY_WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .key_in_bit   (key_in_bit),
    .key_in_valid (key_in_valid),
    .key_in_ready (key_in_ready),
    .key_out      (key_out),
    .key_valid    (key_valid),
    .busy         (busy),
    .load_error   (load_error)
  );

  always #5 clk = ~clk;

  // Reference model: accepted bits are kept in a queue; outputs follow from its length and idle count.
  bit           m_active;
  bit           m_pend;
  int           m_idle;
  bit           m_q[$];
  logic [W-1:0] m_key;
  bit           m_valid;
  bit           m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_pend   = 1'b0;
    m_idle   = 0;
    m_q.delete();
    m_key    = '0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
  endtask

  // Predict the state after the coming rising edge from the inputs that edge will sample.
  task automatic model_step();
    logic [W-1:0] k;
    bit           par;
    if (rst) begin
      model_reset();
    end else if (load_start) begin
      model_reset();
      m_active = 1'b1;
    end else if (m_pend) begin
      for (int i = 0; i < W; i++) k[i] = m_q[i];
      m_key   = k;
      m_valid = 1'b1;
      m_pend  = 1'b0;
    end else if (m_active) begin
      if (key_in_valid) begin
        m_q.push_back(key_in_bit);
        m_idle = 0;
        if (m_q.size() == NBITS) begin
          m_active = 1'b0;
          par = 1'b0;
          foreach (m_q[i]) par ^= m_q[i];
`ifdef LOCK_KEY_PARITY_EN
          if (par == 1'b0) m_pend = 1'b1;
          else m_err = 1'b1;
`else
          m_pend = 1'b1;
`endif
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_active = 1'b0;
          m_err    = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      chk("ready", 32'(key_in_ready), 32'(m_active));
      chk("busy", 32'(busy), 32'(m_active | m_pend));
      chk("key_valid", 32'(key_valid), 32'(m_valid));
      chk("load_error", 32'(load_error), 32'(m_err));
      chk("key_out", key_out, m_key);
      model_step();
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] k, input logic par, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      key_in_valid = 1'b1;
      key_in_bit   = (i < W) ? k[i] : par;
      tick();
      if (gap) begin
        key_in_valid = 1'b0;
        key_in_bit   = 1'($urandom_range(0, 1));
        tick();
      end
    end
    key_in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] k;
    int vprob;
    rst          = 1'b1;
    load_start   = 1'b0;
    key_in_bit   = 1'b0;
    key_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_key_out", key_out, 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(key_in_ready), 32'h0);
    chk("rst_error", 32'(load_error), 32'h0);
    tick();

    // Good key, one bit per cycle: key_valid appears exactly LAT cycles after load_start is raised.
    start();
    send_bits(32'hA5A53C3C, 1'b0, NBITS, 1'b0);
    chk("lat_valid_early", 32'(key_valid), 32'h0);
    chk("commit_ready_low", 32'(key_in_ready), 32'h0);
    chk("commit_busy", 32'(busy), 32'h1);
    tick();
    chk("lat_valid", 32'(key_valid), 32'h1);
    chk("lat_key", key_out, 32'hA5A53C3C);
    chk("lat_error", 32'(load_error), 32'h0);
    chk("model_key_pin", m_key, 32'hA5A53C3C);
    chk("lat_const", 32'(LAT), 32'(W + 2 + NBITS - W));
    repeat (3) tick();

`ifdef LOCK_KEY_PARITY_EN
    start();
    send_bits(32'hA5A53C3C, 1'b1, NBITS, 1'b0);
    chk("par_error", 32'(load_error), 32'h1);
    chk("par_key_out", key_out, 32'h0);
    chk("par_valid", 32'(key_valid), 32'h0);
    key_in_valid = 1'b1;
    repeat (5) tick();
    key_in_valid = 1'b0;
    chk("par_sticky", 32'(load_error), 32'h1);
    chk("par_busy", 32'(busy), 32'h0);
`endif

    // Timeout: 10 bits then silence; the TMO-th idle edge enters ERROR.
    start();
    send_bits(32'h0000_03FF, 1'b0, 10, 1'b0);
    repeat (TMO - 1) tick();
    chk("tmo_not_yet", 32'(load_error), 32'h0);
    tick();
    chk("tmo_error", 32'(load_error), 32'h1);
    chk("tmo_busy", 32'(busy), 32'h0);
    chk("tmo_key_out", key_out, 32'h0);
    chk("model_err_pin", 32'(m_err), 32'h1);
    repeat (3) tick();

    // Junk then restart; the transfer coincident with load_start is dropped.
    start();
    send_bits(32'h0000_0015, 1'b1, 5, 1'b0);
    key_in_valid = 1'b1;
    key_in_bit   = 1'b0;
    start();
    send_bits(32'hFFFFFFFF, 1'b0, NBITS, 1'b0);
    tick();
    chk("junk_key", key_out, 32'hFFFFFFFF);
    chk("junk_valid", 32'(key_valid), 32'h1);
    tick();

    // Commit, then reset in the middle of a second load.
    k = 32'h12345678;
    start();
    send_bits(k, ^k, NBITS, 1'b0);
    tick();
    chk("rst_pre_key", key_out, 32'h12345678);
    start();
    send_bits(32'hDEADBEEF, 1'b0, 20, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_key_out", key_out, 32'h0);
    chk("arst_valid", 32'(key_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ready", 32'(key_in_ready), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    key_in_valid = 1'b1;
    repeat (4) tick();
    key_in_valid = 1'b0;
    chk("post_rst_idle", 32'(busy), 32'h0);

    // Valid toggling every cycle: halved rate never reaches the timeout.
    k = $urandom;
    start();
    send_bits(k, ^k, NBITS, 1'b1);
    chk("toggle_valid", 32'(key_valid), 32'h1);
    chk("toggle_key", key_out, k);
    chk("toggle_err", 32'(load_error), 32'h0);

    // Random traffic at several valid densities, checked cycle by cycle by the model.
    for (int blk = 0; blk < 3; blk++) begin
      vprob = (blk == 0) ? 90 : ((blk == 1) ? 50 : 6);
      for (int c = 0; c < 1200; c++) begin
        load_start   = ($urandom_range(0, 99) < 2);
        key_in_valid = ($urandom_range(0, 99) < vprob);
        key_in_bit   = 1'($urandom_range(0, 1));
        tick();
      end
    end
    load_start   = 1'b0;
    key_in_valid = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lock_key_loader.md
# lock_key_loader

Serial key-provisioning block that delivers the 32-bit unlock key to a random-logic-locked netlist. It accepts key bits one at a time from secure storage over a valid/ready handshake, optionally checks parity, and commits the assembled key atomically. The committed key drives the locked netlist's `keyIn_0_0..keyIn_0_31` ports. The key output holds all-zero (locked, corrupted function) except when a complete, validated key is committed.

## Interface
- `KEY_WIDTH`, 32: key bits; `key_out[i]` drives `keyIn_0_i`.
- `TIMEOUT`, 1024: maximum idle cycles allowed between accepted bits while loading; ≥2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `load_start`  in  1: one-cycle pulse that begins or restarts a key load.
- `key_in_bit`  in  1: serial key bit, LSB (`keyIn_0_0`) first.
- `key_in_valid`  in  1: `key_in_bit` is valid.
- `key_in_ready`  out  1: loader accepts a bit this cycle.
- `key_out`  out  KEY_WIDTH: committed key to the locked netlist.
- `key_valid`  out  1: `key_out` holds a committed key.
- `busy`  out  1: load in progress.
- `load_error`  out  1: last load failed (parity or timeout); sticky.

## Operation
- States: IDLE, SHIFT, PARITY (only with `LOCK_KEY_PARITY_EN`), COMMIT, ERROR.
- IDLE → SHIFT on `load_start`.
  - Clears the shift register, bit counter, timeout counter, `key_out`, `key_valid`, and `load_error`.
- SHIFT
  - `key_in_ready`=1.
  - A transfer is `key_in_valid && key_in_ready`.
  - On each transfer: `shreg <= {key_in_bit, shreg[W-1:1]}`, counter +1, timeout counter cleared.
  - After the KEY_WIDTH-th transfer: go to PARITY, or to COMMIT when the macro is undefined.
- PARITY
  - `key_in_ready`=1; accepts exactly one more bit, `p`.
  - If `^shreg ^ p == 0` (even parity): go to COMMIT; else go to ERROR.
- COMMIT: one cycle; `key_out <= shreg`, `key_valid <= 1`, then go to IDLE.
- ERROR
  - `load_error`=1, `key_out`=0, `key_valid`=0.
  - Stays in ERROR until `load_start`, which behaves as from IDLE.
- Timeout, in SHIFT or PARITY
  - The counter increments on each cycle without a transfer.
  - When it reaches TIMEOUT: go to ERROR.
- `load_start` in any state
  - Restarts immediately (→ SHIFT) with the same clears.
  - Takes priority over a simultaneous transfer, which is dropped.
- `busy`=1 in SHIFT, PARITY, COMMIT.
- `key_in_ready`=0 in IDLE, COMMIT, ERROR; bits presented there are ignored.

## Timing
- Reset values:
  - State: IDLE.
  - `key_out`=0, `key_valid`=0, `busy`=0, `key_in_ready`=0, `load_error`=0.
- `key_in_ready` and `busy` rise the cycle after the `load_start` edge.
- Final handshake sampled at edge E → `key_out` and `key_valid` update at edge E+1.
- Minimum load latency from the `load_start` edge to `key_valid`:
  - KEY_WIDTH+2 cycles without parity.
  - KEY_WIDTH+3 cycles with parity.
- `key_out` never shows a partial key; it changes only at COMMIT, on clear, or on reset.
- Reset asserted mid-load: outputs return to reset values asynchronously; a new `load_start` is needed after release.
- The timeout counter saturates; there is no wrap-around.

## Configuration
- `LOCK_KEY_PARITY_EN` defined
  - PARITY state exists.
  - Each load consumes KEY_WIDTH+1 bits.
  - A parity mismatch goes to ERROR.
- `LOCK_KEY_PARITY_EN` undefined
  - No PARITY state.
  - Each load consumes KEY_WIDTH bits.
  - `load_error` can only come from timeout.

## Test plan
- Parity on, key 0xA5A53C3C LSB-first plus parity 0, one bit per cycle → `key_valid`=1 and `key_out`=0xA5A53C3C at 35 cycles after `load_start`; `load_error`=0.
- Same key with parity bit 1 → `load_error`=1, `key_out`=0, `key_valid`=0; IDLE not re-entered until `load_start`.
- TIMEOUT=16: send 10 bits, then hold `key_in_valid`=0 for 16 cycles → ERROR, `busy`=0, `key_out`=0.
- Send 5 bits of junk, pulse `load_start`, then send 0xFFFFFFFF plus parity 0 → `key_out`=0xFFFFFFFF; the junk has no effect.
- Commit 0x12345678, then assert `rst` during a second load after 20 bits → `key_out`=0 asynchronously, all outputs at reset values.
- `key_in_valid` toggling 1/0 every cycle during a full load → correct key committed, no timeout; `key_in_ready`=0 in COMMIT.
